dmem_arbiter: RTL and testbench



---
 rtl/dmem_arb_pkg.sv | 22 ++
 rtl/rr_pick2.sv | 19 +
 rtl/dmem_arbiter.sv | 152 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
//   state_t : arbiter sequencer states
//   PORT0/1 : requester identifiers (also the encoding of last_grant)
//   addr_ok : word-alignment and full-width range check against the memory depth
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // A word access is legal when it is 4-byte aligned and all four bytes fit.
  // Compared at 64 bits so a top-of-range address can never wrap into range.
  function automatic logic addr_ok(input logic [63:0] addr, input logic [63:0] mem_bytes);
    addr_ok = (addr[1:0] == 2'b00) && (mem_bytes >= 64'd4) && (addr <= mem_bytes - 64'd4);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick.
//   req0, req1  : pending requests
//   last_grant  : port granted most recently
//   valid       : at least one request pending
//   winner      : selected port (the one not granted last when both request)
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic winner
);

  assign valid  = req0 | req1;
  assign winner = (req0 && req1) ? ~last_grant : (req1 ? PORT1 : PORT0);

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer for the shared byte-addressed data
// memory. Serialises a CPU port (0) and a debug/DMA port (1) onto a single
// memread/memwrite interface, checking each access for alignment and range.
//   clk, rst                          : clock, async active-high reset
//   req/we/addr/wdata0,1              : requester inputs, held until ack
//   ack0/1, err0/1                    : one-cycle completion pulse and error flag
//   rdata                             : load data, valid only with an ack
//   mem_addr/mem_wdata/mem_read/
//   mem_write/mem_rdata               : memory side
//
// state  | meaning
// IDLE   | sample requests, pick winner, latch op, range check
// ACCESS | strobe memory for one full cycle from latched op
// RESP   | pulse ack/err of winner, present load data
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_BYTES = 129,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic              err0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic              err1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t              state;
  logic                last_grant;
  logic                op_id;
  logic                op_we;
  logic [ADDR_W-1:0]   op_addr;
  logic [DATA_W-1:0]   op_wdata;
  logic                bad;
  logic                rd_ok;

  logic                pick_valid;
  logic                pick_winner;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_ok;

  rr_pick2 u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  always_comb begin
    sel_we    = (pick_winner == PORT1) ? we1    : we0;
    sel_addr  = (pick_winner == PORT1) ? addr1  : addr0;
    sel_wdata = (pick_winner == PORT1) ? wdata1 : wdata0;
    sel_ok    = addr_ok(64'(sel_addr), 64'(MEM_BYTES));
  end

  // Address/data come straight from the latched op so they are stable for the
  // whole ACCESS cycle and zero otherwise.
  assign mem_addr  = (state == ACCESS) ? op_addr  : '0;
  assign mem_wdata = (state == ACCESS) ? op_wdata : '0;

  // The memory registers read data on the edge that closes ACCESS, so in RESP
  // the load result is only available combinationally from mem_rdata.
  assign rdata = rd_ok ? mem_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= PORT1;
      op_id      <= PORT0;
      op_we      <= 1'b0;
      op_addr    <= '0;
      op_wdata   <= '0;
      bad        <= 1'b0;
      rd_ok      <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
    end else begin
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
      rd_ok <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            op_id      <= pick_winner;
            op_we      <= sel_we;
            op_addr    <= sel_addr;
            op_wdata   <= sel_wdata;
            last_grant <= pick_winner;
            if (!sel_ok) begin
              // Rejected accesses skip the memory entirely and ack next cycle.
              bad   <= 1'b1;
              ack0  <= (pick_winner == PORT0);
              ack1  <= (pick_winner == PORT1);
              err0  <= (pick_winner == PORT0);
              err1  <= (pick_winner == PORT1);
              state <= RESP;
            end else begin
              bad       <= 1'b0;
              mem_read  <= ~sel_we;
              mem_write <= sel_we;
              state     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          ack0      <= (op_id == PORT0);
          ack1      <= (op_id == PORT1);
          err0      <= bad && (op_id == PORT0);
          err1      <= bad && (op_id == PORT1);
          rd_ok     <= ~op_we && ~bad;
          state     <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int MB = 129;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, err0, ack1, err1;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_rdata = '0;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [0:MB-1];

  dmem_arbiter #(.MEM_BYTES(MB), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .err1(err1),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Big-endian byte memory: write on negedge, registered read on posedge.
  always @(negedge clk) begin
    if (mem_write && mem_addr <= 32'(MB - 4)) begin
      mem[int'(mem_addr)]     <= mem_wdata[31:24];
      mem[int'(mem_addr) + 1] <= mem_wdata[23:16];
      mem[int'(mem_addr) + 2] <= mem_wdata[15:8];
      mem[int'(mem_addr) + 3] <= mem_wdata[7:0];
    end
  end

  always @(posedge clk) begin
    if (mem_read && mem_addr <= 32'(MB - 4))
      mem_rdata <= {mem[int'(mem_addr)], mem[int'(mem_addr) + 1],
                    mem[int'(mem_addr) + 2], mem[int'(mem_addr) + 3]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic a0, input logic a1,
                      input logic rd, input logic wr);
    tick();
    chk({tag, ".ack0"}, {31'b0, ack0}, {31'b0, a0});
    chk({tag, ".ack1"}, {31'b0, ack1}, {31'b0, a1});
    chk({tag, ".rd"},   {31'b0, mem_read}, {31'b0, rd});
    chk({tag, ".wr"},   {31'b0, mem_write}, {31'b0, wr});
  endtask

  task automatic reset_dut();
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic p0_store(input string tag, input logic [31:0] a, input logic [31:0] d);
    req0 = 1'b1; we0 = 1'b1; addr0 = a; wdata0 = d;
    step({tag, ".c1"}, 1'b0, 1'b0, 1'b0, 1'b1);
    chk({tag, ".maddr"}, mem_addr, a);
    chk({tag, ".mwdata"}, mem_wdata, d);
    step({tag, ".c2"}, 1'b1, 1'b0, 1'b0, 1'b0);
    chk({tag, ".err0"}, {31'b0, err0}, 32'd0);
    req0 = 1'b0;
    step({tag, ".c3"}, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic p0_load(input string tag, input logic [31:0] a, input logic [31:0] exp);
    req0 = 1'b1; we0 = 1'b0; addr0 = a; wdata0 = '0;
    step({tag, ".c1"}, 1'b0, 1'b0, 1'b1, 1'b0);
    chk({tag, ".maddr"}, mem_addr, a);
    step({tag, ".c2"}, 1'b1, 1'b0, 1'b0, 1'b0);
    chk({tag, ".rdata"}, rdata, exp);
    chk({tag, ".err0"}, {31'b0, err0}, 32'd0);
    req0 = 1'b0;
    step({tag, ".c3"}, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({tag, ".rdata0"}, rdata, 32'd0);
  endtask

  task automatic p1_bad_load(input string tag, input logic [31:0] a);
    req1 = 1'b1; we1 = 1'b0; addr1 = a;
    step({tag, ".c1"}, 1'b0, 1'b1, 1'b0, 1'b0);
    chk({tag, ".err1"}, {31'b0, err1}, 32'd1);
    chk({tag, ".rdata"}, rdata, 32'd0);
    req1 = 1'b0;
    step({tag, ".c2"}, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({tag, ".err1_0"}, {31'b0, err1}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    tick();
    tick();
    chk("rst.ack0", {31'b0, ack0}, 32'd0);
    chk("rst.ack1", {31'b0, ack1}, 32'd0);
    chk("rst.err0", {31'b0, err0}, 32'd0);
    chk("rst.err1", {31'b0, err1}, 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    chk("rst.maddr", mem_addr, 32'd0);
    chk("rst.mwdata", mem_wdata, 32'd0);
    chk("rst.rd", {31'b0, mem_read}, 32'd0);
    chk("rst.wr", {31'b0, mem_write}, 32'd0);
    rst = 1'b0;

    // Store then load at 0x10.
    p0_store("st10", 32'h10, 32'hDEADBEEF);
    p0_load("ld10", 32'h10, 32'hDEADBEEF);

    // Preload words used by later sections.
    p0_store("st00", 32'h0, 32'hA5A50001);
    p0_store("st04", 32'h4, 32'h5A5A0002);
    p0_store("st20", 32'h20, 32'h01020304);

    // Simultaneous requests from reset: port 0 first, then strict alternation.
    reset_dut();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h4;
    step("both.c1", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("both.c1.maddr", mem_addr, 32'h0);
    step("both.c2", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("both.c2.rdata", rdata, 32'hA5A50001);
    step("both.c3", 1'b0, 1'b0, 1'b0, 1'b0);
    step("both.c4", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("both.c4.maddr", mem_addr, 32'h4);
    step("both.c5", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("both.c5.rdata", rdata, 32'h5A5A0002);
    req1 = 1'b0;
    step("both.c6", 1'b0, 1'b0, 1'b0, 1'b0);
    req1 = 1'b1;
    step("both.c7", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("both.c7.maddr", mem_addr, 32'h0);
    step("both.c8", 1'b1, 1'b0, 1'b0, 1'b0);
    req0 = 1'b0;
    step("both.c9", 1'b0, 1'b0, 1'b0, 1'b0);
    step("both.c10", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("both.c10.maddr", mem_addr, 32'h4);
    step("both.c11", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("both.c11.rdata", rdata, 32'h5A5A0002);
    req1 = 1'b0;
    step("both.c12", 1'b0, 1'b0, 1'b0, 1'b0);

    // Port 1 rejected loads: misaligned, out of range, top of address space.
    p1_bad_load("bad06", 32'h6);
    p1_bad_load("bad80", 32'h80);
    p1_bad_load("badtop", 32'hFFFF_FFFC);

    // Range boundary: 0x7C is the last legal word, 0x7D is rejected.
    p0_store("st7c", 32'h7C, 32'h11223344);
    chk("st7c.mem", {mem[124], mem[125], mem[126], mem[127]}, 32'h11223344);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h7D; wdata0 = 32'hFFFFFFFF;
    step("st7d.c1", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("st7d.err0", {31'b0, err0}, 32'd1);
    req0 = 1'b0;
    step("st7d.c2", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("st7d.mem", {mem[124], mem[125], mem[126], mem[127]}, 32'h11223344);

    // Reset during ACCESS of a store, before its negedge.
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'hCAFEF00D;
    step("rstacc.c1", 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("rstacc.wr", {31'b0, mem_write}, 32'd0);
    chk("rstacc.maddr", mem_addr, 32'd0);
    req0 = 1'b0;
    step("rstacc.c2", 1'b0, 1'b0, 1'b0, 1'b0);
    step("rstacc.c3", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step("rstacc.c4", 1'b0, 1'b0, 1'b0, 1'b0);
    step("rstacc.c5", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rstacc.err0", {31'b0, err0}, 32'd0);
    chk("rstacc.rdata", rdata, 32'd0);
    chk("rstacc.mem", {mem[32], mem[33], mem[34], mem[35]}, 32'h01020304);
    p0_store("rest20", 32'h20, 32'hCAFEF00D);
    p0_load("reld20", 32'h20, 32'hCAFEF00D);

    // Port 0 streaming every 3 cycles; port 1 arriving mid-stream goes next.
    reset_dut();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0;
    step("strm.c1", 1'b0, 1'b0, 1'b1, 1'b0);
    step("strm.c2", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("strm.c2.rdata", rdata, 32'hA5A50001);
    step("strm.c3", 1'b0, 1'b0, 1'b0, 1'b0);
    step("strm.c4", 1'b0, 1'b0, 1'b1, 1'b0);
    step("strm.c5", 1'b1, 1'b0, 1'b0, 1'b0);
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h4;
    step("strm.c6", 1'b0, 1'b0, 1'b0, 1'b0);
    step("strm.c7", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("strm.c7.maddr", mem_addr, 32'h4);
    step("strm.c8", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("strm.c8.rdata", rdata, 32'h5A5A0002);
    req1 = 1'b0;
    step("strm.c9", 1'b0, 1'b0, 1'b0, 1'b0);
    step("strm.c10", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("strm.c10.maddr", mem_addr, 32'h0);
    step("strm.c11", 1'b1, 1'b0, 1'b0, 1'b0);
    req0 = 1'b0;
    step("strm.c12", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Strobes must never overlap; counted into the same tallies.
  always @(negedge clk) begin
    if (!rst) chk("excl", {31'b0, mem_read & mem_write}, 32'd0);
  end

endmodule
